// File: rtl/mem_stage_ctrl_if.sv
// Memory-stage bus bundle: pipeline-latch inputs, data-memory handshake and
// pipeline control outputs of the memory-stage controller.
// master = controller view, slave = pipeline/memory environment view.
interface mem_stage_ctrl_if;
  // E/M latch outputs
  logic        memRead_m;
  logic        memWrite_m;
  logic        halt_m;
  logic        exception_m;
  logic [15:0] aluOut_m;
  logic [15:0] read2Data_m;
  // data memory response
  logic        mem_done;
  logic [15:0] mem_rdata;
  // data memory request
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  // pipeline side results / control
  logic [15:0] load_data;
  logic        stall_pipe;
  logic        bubble_mw;
  logic        err_m;
  logic        halted;

  modport master (
    input  memRead_m, memWrite_m, halt_m, exception_m, aluOut_m, read2Data_m,
    input  mem_done, mem_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output load_data, stall_pipe, bubble_mw, err_m, halted
  );

  modport slave (
    output memRead_m, memWrite_m, halt_m, exception_m, aluOut_m, read2Data_m,
    output mem_done, mem_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  load_data, stall_pipe, bubble_mw, err_m, halted
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues each load/store once to a variable-latency
// data memory, freezes upstream latches while the access is outstanding,
// bubbles M/W, flags misaligned/timed-out accesses and parks on HALT.
module mem_stage_ctrl #(
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_ctrl_if.master     bus,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // The wait counter only needs to reach TIMEOUT-1: the issue cycle itself
  // is the first waited cycle, so the abort lands on wait count TIMEOUT-1.
  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  logic req;
  logic misaligned;

  assign req        = (bus.memRead_m | bus.memWrite_m) & ~bus.exception_m;
  assign misaligned = bus.aluOut_m[0];
  assign stall_cnt  = stall_cnt_q;

  // Next-state and combinational outputs; a hit must complete with zero
  // added latency, so requests are driven straight from the E/M latch in IDLE.
  always_comb begin
    state_d        = state_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wcnt_d         = wcnt_q;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = 16'h0000;
    bus.mem_wdata  = 16'h0000;
    bus.load_data  = 16'h0000;
    bus.stall_pipe = 1'b0;
    bus.bubble_mw  = 1'b0;
    bus.err_m      = 1'b0;
    bus.halted     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req && misaligned) begin
            bus.err_m = 1'b1;
          end else if (req) begin
            bus.mem_rd    = bus.memRead_m;
            bus.mem_wr    = bus.memWrite_m;
            bus.mem_addr  = bus.aluOut_m;
            bus.mem_wdata = bus.read2Data_m;
            if (bus.mem_done) begin
              if (bus.memRead_m) bus.load_data = bus.mem_rdata;
            end else begin
              bus.stall_pipe = 1'b1;
              bus.bubble_mw  = 1'b1;
              rd_d           = bus.memRead_m;
              wr_d           = bus.memWrite_m;
              addr_d         = bus.aluOut_m;
              wdata_d        = bus.read2Data_m;
              wcnt_d         = '0;
              state_d        = S_WAIT;
            end
          end else if (bus.halt_m) begin
            state_d = S_HALTED;
          end
        end
        S_WAIT: begin
          // The *_m inputs are frozen here; the captured request is replayed.
          bus.mem_rd    = rd_q;
          bus.mem_wr    = wr_q;
          bus.mem_addr  = addr_q;
          bus.mem_wdata = wdata_q;
          if (bus.mem_done) begin
            if (rd_q) bus.load_data = bus.mem_rdata;
            state_d = S_IDLE;
          end else if (wcnt_q == WCNT_LAST) begin
            // Abort: drop the request, let the pipe advance with a bubble.
            bus.mem_rd    = 1'b0;
            bus.mem_wr    = 1'b0;
            bus.mem_addr  = 16'h0000;
            bus.mem_wdata = 16'h0000;
            bus.err_m     = 1'b1;
            bus.bubble_mw = 1'b1;
            state_d       = S_IDLE;
          end else begin
            bus.stall_pipe = 1'b1;
            bus.bubble_mw  = 1'b1;
            wcnt_d         = wcnt_q + WCNT_W'(1);
          end
        end
        S_HALTED: begin
          bus.stall_pipe = 1'b1;
          bus.bubble_mw  = 1'b1;
          bus.halted     = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM state, captured request and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Saturating count of stalled pipeline cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (bus.stall_pipe && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_ctrl_if bus ();
  logic [CNT_W-1:0] stall_cnt;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an outstanding access with its age in cycles since issue.
  bit          m_pend, m_rd, m_wr, m_halted;
  logic [15:0] m_addr, m_wdata;
  int          m_age, m_cnt;
  bit          n_pend, n_rd, n_wr, n_halted;
  logic [15:0] n_addr, n_wdata;
  int          n_age;
  logic        e_rd, e_wr, e_stall, e_bub, e_err, e_halt;
  logic [15:0] e_addr, e_wdata, e_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pend = 0; m_rd = 0; m_wr = 0; m_halted = 0;
    m_addr = 0; m_wdata = 0; m_age = 0; m_cnt = 0;
  endfunction

  function automatic void model_eval();
    bit req;
    e_rd = 0; e_wr = 0; e_stall = 0; e_bub = 0; e_err = 0; e_halt = 0;
    e_addr = 0; e_wdata = 0; e_load = 0;
    n_pend = m_pend; n_rd = m_rd; n_wr = m_wr; n_halted = m_halted;
    n_addr = m_addr; n_wdata = m_wdata; n_age = m_age;
    if (m_halted) begin
      e_stall = 1; e_bub = 1; e_halt = 1;
    end else if (m_pend) begin
      e_rd = m_rd; e_wr = m_wr; e_addr = m_addr; e_wdata = m_wdata;
      if (bus.mem_done) begin
        if (m_rd) e_load = bus.mem_rdata;
        n_pend = 0;
      end else if (m_age == TIMEOUT) begin
        e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
        e_err = 1; e_bub = 1; n_pend = 0;
      end else begin
        e_stall = 1; e_bub = 1; n_age = m_age + 1;
      end
    end else begin
      req = (bus.memRead_m || bus.memWrite_m) && !bus.exception_m;
      if (req && bus.aluOut_m[0]) begin
        e_err = 1;
      end else if (req) begin
        e_rd = bus.memRead_m; e_wr = bus.memWrite_m;
        e_addr = bus.aluOut_m; e_wdata = bus.read2Data_m;
        if (bus.mem_done) begin
          if (bus.memRead_m) e_load = bus.mem_rdata;
        end else begin
          e_stall = 1; e_bub = 1;
          n_pend = 1; n_age = 1;
          n_rd = bus.memRead_m; n_wr = bus.memWrite_m;
          n_addr = bus.aluOut_m; n_wdata = bus.read2Data_m;
        end
      end else if (bus.halt_m) begin
        n_halted = 1;
      end
    end
  endfunction

  function automatic void model_commit();
    m_pend = n_pend; m_rd = n_rd; m_wr = n_wr; m_halted = n_halted;
    m_addr = n_addr; m_wdata = n_wdata; m_age = n_age;
    if (e_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endfunction

  task automatic check_all();
    chk("mem_rd", bus.mem_rd, e_rd);
    chk("mem_wr", bus.mem_wr, e_wr);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("load_data", bus.load_data, e_load);
    chk("stall_pipe", bus.stall_pipe, e_stall);
    chk("bubble_mw", bus.bubble_mw, e_bub);
    chk("err_m", bus.err_m, e_err);
    chk("halted", bus.halted, e_halt);
    chk("stall_cnt", stall_cnt, m_cnt[CNT_W-1:0]);
  endtask

  task automatic drive(input bit rd, input bit wr, input bit hlt, input bit exc,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input bit done, input logic [15:0] rdata);
    bus.memRead_m = rd; bus.memWrite_m = wr; bus.halt_m = hlt; bus.exception_m = exc;
    bus.aluOut_m = addr; bus.read2Data_m = wd; bus.mem_done = done; bus.mem_rdata = rdata;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
  endtask

  // Called one time unit after a rising edge; returns just before the next.
  task automatic settle_check();
    #3;
    model_eval();
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    model_reset();
    model_eval();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    apply_reset();

    // Load hit
    drive(1, 0, 0, 0, 16'h0010, 16'h0000, 1, 16'hBEEF);
    settle_check();
    chk("hit_load_data", bus.load_data, 16'hBEEF);
    chk("hit_stall", bus.stall_pipe, 1'b0);
    tick();
    idle_inputs();
    cycle();

    // Store miss, done three cycles after issue
    apply_reset();
    drive(0, 1, 0, 0, 16'h0020, 16'h1234, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("miss_wr", bus.mem_wr, 1'b1);
      chk("miss_stall", bus.stall_pipe, 1'b1);
      tick();
    end
    bus.mem_done = 1'b1;
    settle_check();
    chk("miss_wr_done", bus.mem_wr, 1'b1);
    chk("miss_addr_done", bus.mem_addr, 16'h0020);
    chk("miss_wdata_done", bus.mem_wdata, 16'h1234);
    chk("miss_stall_done", bus.stall_pipe, 1'b0);
    tick();
    idle_inputs();
    settle_check();
    chk("miss_wr_after", bus.mem_wr, 1'b0);
    chk("miss_cnt", stall_cnt, 4'd3);
    tick();

    // Misaligned load
    drive(1, 0, 0, 0, 16'h0011, 16'h0000, 0, 16'h0000);
    settle_check();
    chk("misal_err", bus.err_m, 1'b1);
    chk("misal_rd", bus.mem_rd, 1'b0);
    tick();
    idle_inputs();
    settle_check();
    chk("misal_err_pulse", bus.err_m, 1'b0);
    tick();

    // Faulted instruction: no access, no error
    drive(1, 1, 0, 1, 16'h0031, 16'h5555, 0, 16'h0000);
    settle_check();
    chk("exc_rd", bus.mem_rd, 1'b0);
    chk("exc_err", bus.err_m, 1'b0);
    tick();

    // Timeout on a load that never completes
    apply_reset();
    drive(1, 0, 0, 0, 16'h0040, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < TIMEOUT; i++) cycle();
    settle_check();
    chk("to_err", bus.err_m, 1'b1);
    chk("to_stall", bus.stall_pipe, 1'b0);
    chk("to_cnt", stall_cnt, 4'd15);
    tick();
    idle_inputs();
    settle_check();
    chk("to_rd_after", bus.mem_rd, 1'b0);
    tick();

    // Done arriving on the timeout cycle wins
    drive(1, 0, 0, 0, 16'h0044, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < TIMEOUT; i++) cycle();
    bus.mem_done = 1'b1; bus.mem_rdata = 16'hA5A5;
    settle_check();
    chk("to_done_err", bus.err_m, 1'b0);
    chk("to_done_load", bus.load_data, 16'hA5A5);
    tick();
    idle_inputs();

    // Halt, held for 20 cycles, saturating the counter
    apply_reset();
    bus.halt_m = 1'b1;
    cycle();
    bus.halt_m = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    settle_check();
    chk("halt_halted", bus.halted, 1'b1);
    chk("halt_sat", stall_cnt, 4'd15);
    #1;
    apply_reset();
    cycle();

    // Reset in the middle of a miss, then a late done
    drive(1, 0, 0, 0, 16'h0050, 16'h0000, 0, 16'h0000);
    cycle();
    cycle();
    settle_check();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rstw_rd", bus.mem_rd, 1'b0);
    chk("rstw_stall", bus.stall_pipe, 1'b0);
    chk("rstw_bubble", bus.bubble_mw, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
    settle_check();
    chk("late_done_load", bus.load_data, 16'h0000);
    tick();
    idle_inputs();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      if (m_halted && ($urandom_range(0, 3) == 0)) begin
        apply_reset();
      end else begin
        drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
              {$urandom_range(0, 16'hFFFF)} & (($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'hFFFE),
              16'($urandom_range(0, 16'hFFFF)),
              ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 16'hFFFF)));
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
